// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle, valid/ready handshakes.
// Optional zero fast path: define SEQ_BOOTH_MULT_ZERO_SKIP_EN.
module seq_booth_mult #(
   parameter int WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     mcand_q;
   logic [WIDTH-1:0]     acc_q;
   logic [WIDTH-1:0]     mplr_q;
   logic                 qm1_q;
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 busy_q;

   logic [WIDTH:0]       acc_ext;
   logic [WIDTH:0]       mcand_ext;
   logic [WIDTH:0]       sum_d;
   logic [WIDTH-1:0]     acc_d;
   logic [WIDTH-1:0]     mplr_d;
   logic                 qm1_d;
   logic                 last_step;

   // One extra sign bit keeps subtracting -2^(WIDTH-1) from overflowing.
   always_comb begin
      acc_ext   = {acc_q[WIDTH-1], acc_q};
      mcand_ext = {mcand_q[WIDTH-1], mcand_q};
      sum_d     = acc_ext;
      case ({mplr_q[0], qm1_q})
         2'b10:   sum_d = acc_ext - mcand_ext;
         2'b01:   sum_d = acc_ext + mcand_ext;
         default: sum_d = acc_ext;
      endcase
   end

   // Arithmetic shift right of {sum, multiplier, q-1}.
   assign acc_d     = sum_d[WIDTH:1];
   assign mplr_d    = {sum_d[0], mplr_q[WIDTH-1:1]};
   assign qm1_d     = mplr_q[0];
   assign last_step = (cnt_q == CW'(WIDTH - 1));

`ifdef SEQ_BOOTH_MULT_ZERO_SKIP_EN
   logic zero_op;
   assign zero_op = (in_a == '0) || (in_b == '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplr_q      <= '0;
         qm1_q       <= 1'b0;
         cnt_q       <= '0;
         prod_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q    <= in_a;
                  mplr_q     <= in_b;
                  acc_q      <= '0;
                  qm1_q      <= 1'b0;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
`ifdef SEQ_BOOTH_MULT_ZERO_SKIP_EN
                  if (zero_op) begin
                     state_q     <= DONE;
                     prod_q      <= '0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= CALC;
                  end
`else
                  state_q <= CALC;
`endif
               end
            end
            CALC: begin
               acc_q  <= acc_d;
               mplr_q <= mplr_d;
               qm1_q  <= qm1_d;
               cnt_q  <= cnt_q + CW'(1);
               if (last_step) begin
                  state_q     <= DONE;
                  prod_q      <= {acc_d, mplr_d};
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               // Consumption edge only returns to IDLE; a new pair waits a cycle.
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_prod  = prod_q;

endmodule

// File: doc/seq_booth_mult.md
SEQ_BOOTH_MULT -- requirements
Module: seq_booth_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 5, operand width in bits, two's-complement signed; legal range 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair present on in_a/in_b.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port in_a  input  WIDTH  signed multiplicand, fed from the upstream signed counter output.
REQ-007 SHALL have port in_b  input  WIDTH  signed multiplier.
REQ-008 SHALL have port out_valid  output  1  out_prod holds a finished product.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_prod.
REQ-010 SHALL have port out_prod  output  2*WIDTH  signed product in_a*in_b.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 On an edge with IDLE and in_valid=1: SHALL latch in_a and in_b, clear the accumulator and step counter, and go to CALC.
REQ-015 In IDLE with in_valid=0: SHALL hold state; in_a/in_b ignored.
REQ-016 CALC SHALL perform one radix-2 Booth step per cycle, exactly WIDTH steps: examine multiplier LSB pair {q0,q-1}; 10 -> subtract multiplicand, 01 -> add, 00/11 -> no-op; then arithmetic shift right of {acc,q,q-1}.
REQ-017 Booth add/subtract SHALL use a WIDTH+1-bit sign-extended adder so that multiplicand = -2^(WIDTH-1) never overflows.
REQ-018 After the WIDTH-th step edge, SHALL enter DONE with out_prod = exact product; latency from acceptance edge to first cycle with out_valid=1 SHALL be WIDTH+1 edges (6 for WIDTH=5).
REQ-019 out_prod SHALL be registered and held stable throughout DONE.
REQ-020 In DONE, SHALL stay while out_ready=0; on the edge with out_ready=1, SHALL go to IDLE.
REQ-021 No overlap: a new pair SHALL NOT be accepted in the same edge that the result is consumed; in_ready rises the cycle after consumption.
REQ-022 Full range SHALL be exact, including -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2) (256 for WIDTH=5).
REQ-023 out_prod SHALL retain the last product in IDLE and CALC until overwritten on entry to DONE.

Reset
REQ-024 rst=1 at a posedge SHALL force IDLE, out_prod=0, accumulator/counter/latched operands=0, regardless of state; a calculation in progress is discarded with no out_valid.
REQ-025 After reset: in_ready=1, out_valid=0, busy=0 in the first cycle after reset deasserts.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-027 Macro SEQ_BOOTH_MULT_ZERO_SKIP_EN SHALL gate a zero fast path.
REQ-028 With macro defined: on acceptance, if in_a==0 or in_b==0, SHALL go directly to DONE with out_prod=0; out_valid high the cycle after the acceptance edge (latency 1).
REQ-029 Without macro: zero operands SHALL take the full WIDTH+1 latency like any other pair; no zero-detect logic present.

Verification
REQ-030 Reset, then in_a=3, in_b=5, in_valid=1 pulse, out_ready=1 -> out_valid after 6 edges, out_prod=15, then in_ready=1 next cycle.
REQ-031 in_a=-5, in_b=7 -> out_prod=-35 (10'h3DD); in_a=15, in_b=-16 -> out_prod=-240 (10'h310).
REQ-032 in_a=-16, in_b=-16 -> out_prod=256 (10'h100); sweep all 1024 pairs vs. reference product, zero mismatches.
REQ-033 out_ready=0 for 10 cycles in DONE -> out_valid and out_prod stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-034 rst=1 at 3rd CALC cycle -> IDLE, out_prod=0, no out_valid; next pair 2*-3 -> -6 with normal latency.
REQ-035 in_a=0, in_b=9: with SEQ_BOOTH_MULT_ZERO_SKIP_EN -> out_valid after 1 edge, out_prod=0; without -> after 6 edges, out_prod=0.
